ram_dp_sync_be: RTL and testbench

//  True dual-port synchronous RAM, next generation of the team's dual-port memory.

---
 rtl/ram_dp_sync_be.sv | 137 +++++++++++++
 tb/tb_ram_dp_sync_be.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/ram_dp_sync_be.sv
// True dual-port synchronous RAM with per-lane byte enables, selectable read latency,
// selectable cross-port read-during-write behaviour and a post-reset zeroing sweep.
module ram_dp_sync_be #(
    parameter int DWIDTH         = 32,
    parameter int AWIDTH         = 8,
    parameter int BWIDTH         = 8,
    parameter int RD_LAT         = 1,
    parameter int RDW_MODE       = 0,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    output logic                       busy,
    output logic                       collision,
    input  logic                       cs0,
    input  logic                       we0,
    input  logic [DWIDTH/BWIDTH-1:0]   be0,
    input  logic [AWIDTH-1:0]          addr0,
    input  logic [DWIDTH-1:0]          wdata0,
    output logic [DWIDTH-1:0]          rdata0,
    output logic                       rvalid0,
    input  logic                       cs1,
    input  logic                       we1,
    input  logic [DWIDTH/BWIDTH-1:0]   be1,
    input  logic [AWIDTH-1:0]          addr1,
    input  logic [DWIDTH-1:0]          wdata1,
    output logic [DWIDTH-1:0]          rdata1,
    output logic                       rvalid1
);
    // state   | meaning
    // S_CLEAR | sweeping zeros into mem[clr_cnt], requests ignored
    // S_READY | both ports serviced every cycle
    localparam int NBYTES    = DWIDTH / BWIDTH;
    localparam int RAM_DEPTH = 1 << AWIDTH;

    typedef enum logic {S_CLEAR, S_READY} state_t;

    state_t              state;
    logic [AWIDTH-1:0]   clr_cnt;
    logic [DWIDTH-1:0]   mem [RAM_DEPTH];

    logic                wr0, wr1, rd0, rd1;
    logic [DWIDTH-1:0]   rd_word0, rd_word1;
    logic [DWIDTH-1:0]   rdata0_s1, rdata1_s1, rdata0_s2, rdata1_s2;
    logic                rvalid0_s1, rvalid1_s1, rvalid0_s2, rvalid1_s2;

    // A request in the reset cycle is dropped even if busy is low.
    assign wr0 = cs0 &  we0 & ~busy & ~rst;
    assign rd0 = cs0 & ~we0 & ~busy & ~rst;
    assign wr1 = cs1 &  we1 & ~busy & ~rst;
    assign rd1 = cs1 & ~we1 & ~busy & ~rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= (CLEAR_ON_RESET != 0) ? S_CLEAR : S_READY;
            clr_cnt <= '0;
            busy    <= (CLEAR_ON_RESET != 0);
        end else begin
            case (state)
                S_CLEAR: begin
                    clr_cnt <= clr_cnt + 1'b1;
                    if (&clr_cnt) begin
                        state <= S_READY;
                        busy  <= 1'b0;
                    end
                end
                default: busy <= 1'b0;
            endcase
        end
    end

    // Port 1 lanes are written first so port 0 overrides lanes both ports enable.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == S_CLEAR) begin
                mem[clr_cnt] <= '0;
            end else begin
                for (int i = 0; i < NBYTES; i++) begin
                    if (wr1 && be1[i])
                        mem[addr1][i*BWIDTH +: BWIDTH] <= wdata1[i*BWIDTH +: BWIDTH];
                end
                for (int i = 0; i < NBYTES; i++) begin
                    if (wr0 && be0[i])
                        mem[addr0][i*BWIDTH +: BWIDTH] <= wdata0[i*BWIDTH +: BWIDTH];
                end
            end
        end
    end

    // New-data mode forwards the other port's enabled write lanes into the read word.
    always_comb begin
        rd_word0 = mem[addr0];
        rd_word1 = mem[addr1];
        if (RDW_MODE != 0) begin
            for (int i = 0; i < NBYTES; i++) begin
                if (wr1 && be1[i] && (addr1 == addr0))
                    rd_word0[i*BWIDTH +: BWIDTH] = wdata1[i*BWIDTH +: BWIDTH];
                if (wr0 && be0[i] && (addr0 == addr1))
                    rd_word1[i*BWIDTH +: BWIDTH] = wdata0[i*BWIDTH +: BWIDTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            collision  <= 1'b0;
            rdata0_s1  <= '0;
            rdata1_s1  <= '0;
            rdata0_s2  <= '0;
            rdata1_s2  <= '0;
            rvalid0_s1 <= 1'b0;
            rvalid1_s1 <= 1'b0;
            rvalid0_s2 <= 1'b0;
            rvalid1_s2 <= 1'b0;
        end else begin
            collision  <= wr0 & wr1 & (addr0 == addr1);
            rvalid0_s1 <= rd0;
            rvalid1_s1 <= rd1;
            rvalid0_s2 <= rvalid0_s1;
            rvalid1_s2 <= rvalid1_s1;
            if (rd0)
                rdata0_s1 <= rd_word0;
            if (rd1)
                rdata1_s1 <= rd_word1;
            if (rvalid0_s1)
                rdata0_s2 <= rdata0_s1;
            if (rvalid1_s1)
                rdata1_s2 <= rdata1_s1;
        end
    end

    assign rdata0  = (RD_LAT == 2) ? rdata0_s2  : rdata0_s1;
    assign rdata1  = (RD_LAT == 2) ? rdata1_s2  : rdata1_s1;
    assign rvalid0 = (RD_LAT == 2) ? rvalid0_s2 : rvalid0_s1;
    assign rvalid1 = (RD_LAT == 2) ? rvalid1_s2 : rvalid1_s1;

endmodule

// File: tb/tb_ram_dp_sync_be.sv
// Directed bench: two instances share stimulus; dut_a is RD_LAT=1/old-data,
// dut_b is RD_LAT=2/new-data, both with a 16-word array.
module tb_ram_dp_sync_be;
    logic        clk, rst;
    logic        cs0, we0, cs1, we1;
    logic [3:0]  be0, be1, addr0, addr1;
    logic [31:0] wdata0, wdata1;

    logic        a_busy, a_coll, a_rvalid0, a_rvalid1;
    logic [31:0] a_rdata0, a_rdata1;
    logic        b_busy, b_coll, b_rvalid0, b_rvalid1;
    logic [31:0] b_rdata0, b_rdata1;

    int n_checks = 0;
    int n_fail   = 0;

    ram_dp_sync_be #(.DWIDTH(32), .AWIDTH(4), .BWIDTH(8), .RD_LAT(1), .RDW_MODE(0),
                     .CLEAR_ON_RESET(1)) dut_a (
        .clk(clk), .rst(rst), .busy(a_busy), .collision(a_coll),
        .cs0(cs0), .we0(we0), .be0(be0), .addr0(addr0), .wdata0(wdata0),
        .rdata0(a_rdata0), .rvalid0(a_rvalid0),
        .cs1(cs1), .we1(we1), .be1(be1), .addr1(addr1), .wdata1(wdata1),
        .rdata1(a_rdata1), .rvalid1(a_rvalid1)
    );

    ram_dp_sync_be #(.DWIDTH(32), .AWIDTH(4), .BWIDTH(8), .RD_LAT(2), .RDW_MODE(1),
                     .CLEAR_ON_RESET(1)) dut_b (
        .clk(clk), .rst(rst), .busy(b_busy), .collision(b_coll),
        .cs0(cs0), .we0(we0), .be0(be0), .addr0(addr0), .wdata0(wdata0),
        .rdata0(b_rdata0), .rvalid0(b_rvalid0),
        .cs1(cs1), .we1(we1), .be1(be1), .addr1(addr1), .wdata1(wdata1),
        .rdata1(b_rdata1), .rvalid1(b_rvalid1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cs0 = 0; we0 = 0; be0 = 0; addr0 = 0; wdata0 = 0;
        cs1 = 0; we1 = 0; be1 = 0; addr1 = 0; wdata1 = 0;
    endtask

    task automatic set_p(input int p, input logic we, input logic [3:0] be,
                         input logic [3:0] a, input logic [31:0] d);
        if (p == 0) begin
            cs0 = 1; we0 = we; be0 = be; addr0 = a; wdata0 = d;
        end else begin
            cs1 = 1; we1 = we; be1 = be; addr1 = a; wdata1 = d;
        end
    endtask

    task automatic wr(input int p, input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
        idle();
        set_p(p, 1'b1, be, a, d);
        step();
        idle();
    endtask

    // Single read: dut_a answers after one edge, dut_b after two.
    task automatic rd(input int p, input logic [3:0] a, input logic [31:0] exp_a,
                      input logic [31:0] exp_b);
        idle();
        set_p(p, 1'b0, 4'h0, a, 32'h0);
        step();
        idle();
        check("rd_a_data",  (p == 0) ? a_rdata0  : a_rdata1,  exp_a);
        check("rd_a_valid", (p == 0) ? a_rvalid0 : a_rvalid1, 1);
        check("rd_b_early", (p == 0) ? b_rvalid0 : b_rvalid1, 0);
        step();
        check("rd_b_data",  (p == 0) ? b_rdata0  : b_rdata1,  exp_b);
        check("rd_b_valid", (p == 0) ? b_rvalid0 : b_rvalid1, 1);
        check("rd_a_pulse", (p == 0) ? a_rvalid0 : a_rvalid1, 0);
        check("rd_a_hold",  (p == 0) ? a_rdata0  : a_rdata1,  exp_a);
    endtask

    // Wait out the clear sweep while hammering writes to addr 0 and reads on port 1.
    task automatic wait_clear();
        int   n;
        logic any_rv;
        n = 0;
        any_rv = 0;
        set_p(0, 1'b1, 4'hf, 4'd0, 32'hBAD0BAD0);
        set_p(1, 1'b0, 4'h0, 4'd3, 32'h0);
        while (a_busy && n < 100) begin
            step();
            n++;
            if (a_rvalid0 | a_rvalid1 | b_rvalid0 | b_rvalid1)
                any_rv = 1;
        end
        idle();
        check("clear_cycles", 32'(n), 32'd16);
        check("busy_rvalid", {31'b0, any_rv}, 32'd0);
        check("busy_b_low", {31'b0, b_busy}, 32'd0);
    endtask

    logic [31:0] d5 [3];

    initial begin
        idle();
        rst = 1;
        step();
        step();
        check("rst_busy_a",   {31'b0, a_busy},    1);
        check("rst_busy_b",   {31'b0, b_busy},    1);
        check("rst_coll",     {31'b0, a_coll},    0);
        check("rst_rvalid_b", {31'b0, b_rvalid0}, 0);
        check("rst_rdata_a",  a_rdata0, 0);
        check("rst_rdata_b",  b_rdata1, 0);
        rst = 0;
        wait_clear();

        // Whole array reads back zero, alternating ports.
        for (int a = 0; a < 16; a++)
            rd(a % 2, 4'(a), 32'h0, 32'h0);

        // Cross-port write while the other port reads: old vs merged data.
        wr(0, 4'd3, 32'hDEADBEEF, 4'hf);
        rd(1, 4'd3, 32'hDEADBEEF, 32'hDEADBEEF);
        idle();
        set_p(0, 1'b0, 4'h0, 4'd3, 32'h0);
        set_p(1, 1'b1, 4'h1, 4'd3, 32'h00000011);
        step();
        idle();
        check("t2_rdw_a", a_rdata0, 32'hDEADBEEF);
        check("t2_rv_a",  {31'b0, a_rvalid0}, 1);
        check("t2_coll",  {31'b0, a_coll}, 0);
        step();
        check("t2_rdw_b", b_rdata0, 32'hDEADBE11);
        check("t2_rv_b",  {31'b0, b_rvalid0}, 1);
        rd(0, 4'd3, 32'hDEADBE11, 32'hDEADBE11);

        // Same-address double write: port 0 wins shared lanes.
        idle();
        set_p(0, 1'b1, 4'b0011, 4'd5, 32'hAAAAAAAA);
        set_p(1, 1'b1, 4'b1110, 4'd5, 32'h55555555);
        step();
        idle();
        check("t3_coll_a", {31'b0, a_coll}, 1);
        check("t3_coll_b", {31'b0, b_coll}, 1);
        step();
        check("t3_coll_end", {31'b0, a_coll}, 0);
        rd(1, 4'd5, 32'h5555AAAA, 32'h5555AAAA);

        // Both ports read the same word.
        set_p(0, 1'b0, 4'h0, 4'd5, 32'h0);
        set_p(1, 1'b0, 4'h0, 4'd5, 32'h0);
        step();
        idle();
        check("dual_rd_a0", a_rdata0, 32'h5555AAAA);
        check("dual_rd_a1", a_rdata1, 32'h5555AAAA);
        check("dual_rd_coll", {31'b0, a_coll}, 0);
        step();
        check("dual_rd_b0", b_rdata0, 32'h5555AAAA);
        check("dual_rd_b1", b_rdata1, 32'h5555AAAA);

        // Full-word overwrite on port 0 while port 1 reads.
        wr(1, 4'd7, 32'h01020304, 4'hf);
        set_p(0, 1'b1, 4'hf, 4'd7, 32'hFFFFFFFF);
        set_p(1, 1'b0, 4'h0, 4'd7, 32'h0);
        step();
        idle();
        check("t4_rdw_a", a_rdata1, 32'h01020304);
        check("t4_coll",  {31'b0, a_coll}, 0);
        step();
        check("t4_rdw_b", b_rdata1, 32'hFFFFFFFF);
        rd(0, 4'd7, 32'hFFFFFFFF, 32'hFFFFFFFF);

        // Byte-enable corner cases.
        wr(0, 4'd9, 32'hFFFFFFFF, 4'b0000);
        rd(1, 4'd9, 32'h0, 32'h0);
        wr(1, 4'd10, 32'hA5A5A5A5, 4'b0100);
        rd(0, 4'd10, 32'h00A50000, 32'h00A50000);

        // Back-to-back reads of 0,1,2 on port 0.
        wr(0, 4'd1, 32'h11111111, 4'hf);
        wr(0, 4'd2, 32'h22222222, 4'hf);
        d5[0] = 32'h0;
        d5[1] = 32'h11111111;
        d5[2] = 32'h22222222;
        for (int k = 0; k < 6; k++) begin
            idle();
            if (k < 3)
                set_p(0, 1'b0, 4'h0, 4'(k), 32'h0);
            step();
            check("t5_rv_a", {31'b0, a_rvalid0}, (k < 3) ? 32'd1 : 32'd0);
            check("t5_data_a", a_rdata0, d5[(k < 3) ? k : 2]);
            check("t5_rv_b", {31'b0, b_rvalid0}, (k >= 1 && k <= 3) ? 32'd1 : 32'd0);
            if (k >= 1)
                check("t5_data_b", b_rdata0, d5[(k - 1 < 2) ? k - 1 : 2]);
        end
        idle();

        // Reset in mid-clear restarts the full sweep.
        wr(0, 4'd12, 32'hCAFEF00D, 4'hf);
        rst = 1;
        step();
        rst = 0;
        for (int i = 0; i < 9; i++)
            step();
        rst = 1;
        step();
        rst = 0;
        check("t6_busy_rst", {31'b0, a_busy}, 1);
        wait_clear();
        rd(0, 4'd0,  32'h0, 32'h0);
        rd(1, 4'd12, 32'h0, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
